oyun_serisi: RTL and testbench
==============================

OYUN_SERISI -- requirements
Module: oyun_serisi

Interface
REQ-001 Parameter ROUNDS, default 3, maximum decisive rounds in a match; SHALL be odd and >= 1.
REQ-002 Parameter MAX_TIES, default 7, consecutive tied rounds allowed before the match is declared drawn; SHALL be >= 1.
REQ-003 Derived width: CW = $clog2(ROUNDS+1); TW = $clog2(MAX_TIES+1).
REQ-004 Clocking and reset: single clock domain; reset is asynchronous, active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  begin a new match; sampled only in IDLE or DONE.
REQ-008 move_valid  input  1  move_a and move_b hold a round's moves.
REQ-009 move_a  input  2  player A move: 00 rock, 01 paper, 10 scissors, 11 invalid.
REQ-010 move_b  input  2  player B move, same encoding.
REQ-011 move_ready  output  1  block accepts a move pair.
REQ-012 busy  output  1  match in progress.
REQ-013 done  output  1  match finished; winner valid.
REQ-014 winner  output  2  00 none, 01 A, 10 B, 11 draw.
REQ-015 score_a, score_b  output  CW  rounds won per player.
REQ-016 tie_cnt  output  TW  current consecutive-tie count.
REQ-017 last_result  output  2  latest round verdict: 00 none, 01 A, 10 B, 11 tie.

Function
REQ-018 The FSM SHALL have four states: IDLE, PLAY, JUDGE and DONE.
REQ-019 IDLE/DONE with start=1: clear scores, tie_cnt, winner, last_result and done, then enter PLAY next cycle.
REQ-020 move_ready SHALL be 1 only in PLAY; a transfer occurs when move_valid and move_ready are both 1.
REQ-021 On transfer, moves are registered and the FSM enters JUDGE; no second move is accepted until PLAY is re-entered.
REQ-022 Verdict rules: paper beats rock, scissors beats paper, rock beats scissors; equal valid moves tie.
REQ-023 One invalid move awards the round to the opponent; both invalid is a tie.
REQ-024 In JUDGE, the verdict updates last_result, the winner's score (+1) and tie_cnt in the same cycle; a win clears tie_cnt and a tie increments it.
REQ-025 After JUDGE, the FSM enters DONE if either updated score equals (ROUNDS+1)/2, because the match ends early once a majority is reached; winner is set to that player.
REQ-026 After JUDGE, the FSM enters DONE with winner=11 if updated tie_cnt equals MAX_TIES.
REQ-027 Otherwise the FSM returns to PLAY.
REQ-028 Latency: a transfer at edge N updates scores at edge N+1; done is 1 after edge N+1 when the match ends.
REQ-029 busy SHALL be 1 in PLAY and JUDGE only; done SHALL be 1 in DONE only and SHALL hold until start or reset.
REQ-030 start asserted in PLAY or JUDGE SHALL be ignored.
REQ-031 Scores SHALL never exceed (ROUNDS+1)/2 and SHALL not wrap.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE with all outputs 0, regardless of state, including mid-match and during JUDGE.
REQ-033 Reset release SHALL be synchronised in the block's own clock domain so that the first post-reset edge is clean.

Structure
REQ-034 Move encodings, verdict/winner codes and the FSM state enum SHALL live in shared package oyun_pkg.
REQ-035 Round comparison SHALL be a combinational sub-module tur_karar with ports move_a, move_b and verdict[1:0], instantiated once.

Verification
REQ-036 Reset, start, then pairs (paper,rock),(scissors,paper) -> score_a=2 and winner=01, with done 1 cycle after the second transfer and no third move_ready.
REQ-037 ROUNDS=5, alternating A/B wins, then B wins twice -> scores 2/3, winner=10 after the 5th round.
REQ-038 MAX_TIES=3, three pairs (rock,rock) -> tie_cnt=3 and winner=11; a tie, then an A win, then a tie -> tie_cnt=1.
REQ-039 (11,rock) -> B wins the round; (11,11) -> tie.
REQ-040 rst_n pulsed low during JUDGE -> all outputs 0 on the same cycle with no clock edge needed, and the FSM is in IDLE afterwards.
REQ-041 start held high throughout a match -> scores unchanged by start while busy; start accepted again in DONE clears the outputs.

Source files
------------

// File: rtl/oyun_pkg.sv
// oyun_pkg: shared move/verdict/winner codes, FSM state enum and the move-beats rule
package oyun_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, JUDGE, DONE} state_t;
  localparam logic [1:0] ROCK     = 2'b00;
  localparam logic [1:0] PAPER    = 2'b01;
  localparam logic [1:0] SCISSORS = 2'b10;
  localparam logic [1:0] INVALID  = 2'b11;
  localparam logic [1:0] V_NONE   = 2'b00;
  localparam logic [1:0] V_A      = 2'b01;
  localparam logic [1:0] V_B      = 2'b10;
  localparam logic [1:0] V_TIE    = 2'b11;
  localparam logic [1:0] W_NONE   = 2'b00;
  localparam logic [1:0] W_A      = 2'b01;
  localparam logic [1:0] W_B      = 2'b10;
  localparam logic [1:0] W_DRAW   = 2'b11;
  function automatic logic beats(input logic [1:0] x, input logic [1:0] y);
    return (x == PAPER && y == ROCK) || (x == SCISSORS && y == PAPER) || (x == ROCK && y == SCISSORS);
  endfunction
endpackage

// File: rtl/tur_karar.sv
// tur_karar: combinational round verdict; move_a/move_b in, verdict out (01 A, 10 B, 11 tie)
module tur_karar
  import oyun_pkg::*;
(
  input  logic [1:0] move_a,
  input  logic [1:0] move_b,
  output logic [1:0] verdict
);
  // An invalid move forfeits to the opponent; two invalid moves cancel out as a tie.
  always_comb
    verdict = (move_a == INVALID && move_b == INVALID) ? V_TIE :
              (move_a == INVALID)                      ? V_B   :
              (move_b == INVALID)                      ? V_A   :
              (move_a == move_b)                       ? V_TIE :
              beats(move_a, move_b)                    ? V_A   : V_B;
endmodule

// File: rtl/oyun_serisi.sv
// oyun_serisi: best-of-ROUNDS rock/paper/scissors match controller; clk/rst_n, start, move handshake in; busy/done/winner/scores/tie_cnt/last_result out
module oyun_serisi
  import oyun_pkg::*;
#(
  parameter  int ROUNDS   = 3,
  parameter  int MAX_TIES = 7,
  localparam int CW       = $clog2(ROUNDS + 1),
  localparam int TW       = $clog2(MAX_TIES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          move_valid,
  input  logic [1:0]    move_a,
  input  logic [1:0]    move_b,
  output logic          move_ready,
  output logic          busy,
  output logic          done,
  output logic [1:0]    winner,
  output logic [CW-1:0] score_a,
  output logic [CW-1:0] score_b,
  output logic [TW-1:0] tie_cnt,
  output logic [1:0]    last_result
);
  localparam logic [CW-1:0] MAJ  = CW'((ROUNDS + 1) / 2);
  localparam logic [TW-1:0] TMAX = TW'(MAX_TIES);
  logic [1:0] rs;
  logic rst_i;
  state_t st, st_n;
  logic [1:0] ma, mb, ma_n, mb_n, v, win_n, lr_n;
  logic [CW-1:0] sa_n, sb_n, ja, jb;
  logic [TW-1:0] tc_n, jt;
  // Assertion is immediate, release is delayed two edges so the first functional edge is clean.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rs <= 2'b00;
    else        rs <= {rs[0], 1'b1};
  assign rst_i = rs[1];
  tur_karar u_karar (.move_a(ma), .move_b(mb), .verdict(v));
  assign ja = score_a + CW'(v == V_A);
  assign jb = score_b + CW'(v == V_B);
  assign jt = (v == V_TIE) ? tie_cnt + TW'(1) : '0;
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      st <= IDLE;
      ma <= '0;
      mb <= '0;
      score_a <= '0;
      score_b <= '0;
      tie_cnt <= '0;
      last_result <= V_NONE;
      winner <= W_NONE;
    end else begin
      st <= st_n;
      ma <= ma_n;
      mb <= mb_n;
      score_a <= sa_n;
      score_b <= sb_n;
      tie_cnt <= tc_n;
      last_result <= lr_n;
      winner <= win_n;
    end
  always_comb begin
    st_n = st;
    ma_n = ma;
    mb_n = mb;
    sa_n = score_a;
    sb_n = score_b;
    tc_n = tie_cnt;
    lr_n = last_result;
    win_n = winner;
    case (st)
      IDLE, DONE: if (start) begin
        sa_n = '0;
        sb_n = '0;
        tc_n = '0;
        lr_n = V_NONE;
        win_n = W_NONE;
        st_n = PLAY;
      end
      PLAY: if (move_valid) begin
        ma_n = move_a;
        mb_n = move_b;
        st_n = JUDGE;
      end
      JUDGE: begin
        sa_n = ja;
        sb_n = jb;
        tc_n = jt;
        lr_n = v;
        // Reaching the majority ends the match early; scores therefore never pass MAJ.
        win_n = (ja == MAJ) ? W_A : (jb == MAJ) ? W_B : (jt == TMAX) ? W_DRAW : W_NONE;
        st_n = (win_n != W_NONE) ? DONE : PLAY;
      end
      default: st_n = IDLE;
    endcase
  end
  assign move_ready = st == PLAY;
  assign busy = st == PLAY || st == JUDGE;
  assign done = st == DONE;
endmodule

// File: tb/tb_oyun_serisi.sv
// tb_oyun_serisi: directed table-driven bench for oyun_serisi (ROUNDS=3/MAX_TIES=3 and ROUNDS=5/MAX_TIES=7 instances)
module tb_oyun_serisi;
  logic clk = 0, rst_n = 0, start = 0, move_valid = 0;
  logic [1:0] move_a = 0, move_b = 0;
  logic r3, b3, d3;
  logic [1:0] w3, sa3, sb3, tc3, lr3;
  logic r5, b5, d5;
  logic [1:0] w5, lr5;
  logic [2:0] sa5, sb5, tc5;
  int errors = 0, checks = 0;
  typedef struct { logic [1:0] a, b, lr; } vec_t;
  vec_t tbl[16];

  always #5 clk = ~clk;

  oyun_serisi #(.ROUNDS(3), .MAX_TIES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid), .move_a(move_a), .move_b(move_b),
    .move_ready(r3), .busy(b3), .done(d3), .winner(w3), .score_a(sa3), .score_b(sb3),
    .tie_cnt(tc3), .last_result(lr3));

  oyun_serisi #(.ROUNDS(5), .MAX_TIES(7)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid), .move_a(move_a), .move_b(move_b),
    .move_ready(r5), .busy(b5), .done(d5), .winner(w5), .score_a(sa5), .score_b(sb5),
    .tie_cnt(tc5), .last_result(lr5));

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0;
    move_valid = 0;
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    repeat (2) tick();
  endtask

  task automatic begin_match();
    start = 1;
    tick();
    start = 0;
  endtask

  // Transfers one move pair on the chosen instance, then lets JUDGE complete.
  task automatic play(input logic [1:0] a, input logic [1:0] b, input bit five);
    int k;
    k = 0;
    while (!(five ? r5 : r3) && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) chk("ready_timeout", 0, 1);
    move_a = a;
    move_b = b;
    move_valid = 1;
    tick();
    move_valid = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{2'd0, 2'd0, 2'd3}, '{2'd0, 2'd1, 2'd2}, '{2'd0, 2'd2, 2'd1}, '{2'd0, 2'd3, 2'd1},
      '{2'd1, 2'd0, 2'd1}, '{2'd1, 2'd1, 2'd3}, '{2'd1, 2'd2, 2'd2}, '{2'd1, 2'd3, 2'd1},
      '{2'd2, 2'd0, 2'd2}, '{2'd2, 2'd1, 2'd1}, '{2'd2, 2'd2, 2'd3}, '{2'd2, 2'd3, 2'd1},
      '{2'd3, 2'd0, 2'd2}, '{2'd3, 2'd1, 2'd2}, '{2'd3, 2'd2, 2'd2}, '{2'd3, 2'd3, 2'd3}};

    do_reset();
    chk("rst_ready", r3, 0);
    chk("rst_busy", b3, 0);
    chk("rst_done", d3, 0);
    chk("rst_winner", w3, 0);
    chk("rst_score_a", sa3, 0);
    chk("rst_tie", tc3, 0);
    chk("rst_last", lr3, 0);

    for (int i = 0; i < 16; i++) begin
      do_reset();
      begin_match();
      play(tbl[i].a, tbl[i].b, 0);
      chk($sformatf("verdict_%0d", i), lr3, tbl[i].lr);
      chk($sformatf("sa_%0d", i), sa3, tbl[i].lr == 2'd1 ? 1 : 0);
      chk($sformatf("sb_%0d", i), sb3, tbl[i].lr == 2'd2 ? 1 : 0);
      chk($sformatf("tie_%0d", i), tc3, tbl[i].lr == 2'd3 ? 1 : 0);
      chk($sformatf("ready_%0d", i), r3, 1);
    end

    do_reset();
    begin_match();
    chk("m1_busy", b3, 1);
    play(2'd1, 2'd0, 0);
    chk("m1_sa1", sa3, 1);
    chk("m1_done_early", d3, 0);
    move_a = 2'd2;
    move_b = 2'd1;
    move_valid = 1;
    tick();
    move_valid = 0;
    chk("m1_judge_done", d3, 0);
    chk("m1_judge_ready", r3, 0);
    tick();
    chk("m1_done", d3, 1);
    chk("m1_sa2", sa3, 2);
    chk("m1_winner", w3, 1);
    chk("m1_busy_end", b3, 0);
    move_valid = 1;
    repeat (3) tick();
    move_valid = 0;
    chk("m1_no_ready", r3, 0);
    chk("m1_sa_hold", sa3, 2);
    chk("m1_done_hold", d3, 1);

    do_reset();
    begin_match();
    play(2'd1, 2'd0, 1);
    play(2'd0, 2'd1, 1);
    play(2'd1, 2'd0, 1);
    play(2'd0, 2'd1, 1);
    chk("m5_done4", d5, 0);
    chk("m5_sa4", sa5, 2);
    chk("m5_sb4", sb5, 2);
    play(2'd1, 2'd2, 1);
    chk("m5_done", d5, 1);
    chk("m5_sa", sa5, 2);
    chk("m5_sb", sb5, 3);
    chk("m5_winner", w5, 2);

    do_reset();
    begin_match();
    play(2'd0, 2'd0, 0);
    play(2'd0, 2'd0, 0);
    chk("t_tie2", tc3, 2);
    chk("t_done2", d3, 0);
    play(2'd0, 2'd0, 0);
    chk("t_tie3", tc3, 3);
    chk("t_draw", w3, 3);
    chk("t_done", d3, 1);
    begin_match();
    chk("t_restart_tie", tc3, 0);
    chk("t_restart_win", w3, 0);
    play(2'd0, 2'd0, 0);
    play(2'd1, 2'd0, 0);
    chk("t_win_clears", tc3, 0);
    play(2'd0, 2'd0, 0);
    chk("t_tie1", tc3, 1);
    chk("t_sa1", sa3, 1);
    chk("t_busy", b3, 1);

    do_reset();
    begin_match();
    play(2'd1, 2'd0, 0);
    move_a = 2'd0;
    move_b = 2'd1;
    move_valid = 1;
    tick();
    move_valid = 0;
    chk("r_pre_busy", b3, 1);
    chk("r_pre_sa", sa3, 1);
    rst_n = 0;
    #1;
    chk("r_busy", b3, 0);
    chk("r_ready", r3, 0);
    chk("r_done", d3, 0);
    chk("r_sa", sa3, 0);
    chk("r_last", lr3, 0);
    chk("r_winner", w3, 0);
    repeat (2) tick();
    rst_n = 1;
    repeat (3) tick();
    chk("r_idle_busy", b3, 0);
    chk("r_idle_done", d3, 0);
    chk("r_idle_sb", sb3, 0);

    do_reset();
    start = 1;
    tick();
    play(2'd1, 2'd0, 0);
    chk("s_sa1", sa3, 1);
    chk("s_busy", b3, 1);
    play(2'd1, 2'd0, 0);
    chk("s_done", d3, 1);
    chk("s_sa2", sa3, 2);
    chk("s_winner", w3, 1);
    tick();
    chk("s_clear_sa", sa3, 0);
    chk("s_clear_win", w3, 0);
    chk("s_clear_done", d3, 0);
    chk("s_restart_busy", b3, 1);
    start = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
